// File: rtl/ctl_pkg.sv
// Shared definitions for the control sequencer: opcodes, size codes, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package ctl_pkg;

  localparam logic [7:0] CTL_NOP        = 8'h00;
  localparam logic [7:0] CTL_LOAD_IMM   = 8'h01;
  localparam logic [7:0] CTL_READ_ADDR  = 8'h02;
  localparam logic [7:0] CTL_WRITE_ADDR = 8'h03;

  localparam logic [1:0] SZ_1 = 2'd0;
  localparam logic [1:0] SZ_2 = 2'd1;
  localparam logic [1:0] SZ_4 = 2'd2;
  localparam logic [1:0] SZ_8 = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    RSRC = 3'd2,
    BUS  = 3'd3,
    WB   = 3'd4
  } ctl_state_t;

  // Byte count for a size code: 1, 2, 4 or 8.
  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ctl_byte_seq.sv
// Byte-serial bus sequencer: walks count bytes from base over a req/ack handshake.
// Latency: bus_req rises the cycle after start; one byte per acked cycle, back-to-back on zero wait.
// Backpressure: address, direction and write byte are held while bus_req && !bus_ack.
module ctl_byte_seq #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        count,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_data_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] addr_out,
  output logic [7:0]        data_out,
  output logic [7:0]        rbyte,
  output logic              rvalid,
  output logic              last,
  output logic [3:0]        idx
);

  logic              active;
  logic [3:0]        idx_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic [DATA_W-1:0] shreg;
  logic              is_last;

  assign is_last = (idx_q == cnt_q - 4'd1);

  // Transfer bookkeeping: load on start, advance one byte per ack, stop after the final ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
      base_q <= '0;
      we_q   <= 1'b0;
      shreg  <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx_q  <= '0;
      cnt_q  <= count;
      base_q <= base;
      we_q   <= we;
      shreg  <= wdata;
    end else if (active && bus_ack) begin
      if (is_last) begin
        // Keep index and write byte so the bus outputs hold their final value.
        active <= 1'b0;
      end else begin
        idx_q <= idx_q + 4'd1;
        shreg <= shreg >> 8;
      end
    end
  end

  // Address wraps naturally by truncation to ADDR_W.
  assign addr_out = base_q + ADDR_W'(idx_q);
  assign data_out = shreg[7:0];
  assign bus_we   = we_q;
  assign bus_req  = active;
  assign rbyte    = bus_data_in;
  assign rvalid   = active && bus_ack && !we_q;
  assign last     = active && bus_ack && is_last;
  assign idx      = idx_q;

endmodule

// File: rtl/ctl_seq.sv
// Control sequencer: NOP / load-immediate / multi-byte LE bus load and store to a register bank.
// Latency: NOP, LOAD_IMM and errors complete 1 cycle after accept; bus ops complete n+2 cycles after on zero-wait acks.
// Backpressure: one op in flight; op_ready low from accept until return to IDLE; bus stalls via bus_ack.
module ctl_seq
  import ctl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 17,
  parameter int SEL_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        ctl_op,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic              err,
  output logic              regbank_we,
  output logic [SEL_W-1:0]  regbank_sel,
  output logic [DATA_W-1:0] regbank_valout,
  output logic [SEL_W-1:0]  regbank_rsel,
  input  logic [DATA_W-1:0] regbank_rdata,
  output logic              bus_req,
  output logic              bus_we,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] addr_out,
  output logic [7:0]        data_out,
  input  logic [7:0]        bus_data_in
);

  ctl_state_t        state, state_nxt;
  logic [7:0]        op_q;
  logic [SEL_W-1:0]  sel_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] val_q;
  logic              accept;
  logic              too_big;
  logic              seq_start;
  logic              seq_we;
  logic [7:0]        rbyte;
  logic              rvalid;
  logic              seq_last;
  logic [3:0]        idx;

  assign op_ready = (state == IDLE) && !rst;
  assign accept   = op_valid && op_ready;
  assign too_big  = (32'(nbytes(size_q)) << 3) > 32'(DATA_W);
  assign acc_nxt  = acc | (DATA_W'(rbyte) << {idx, 3'b000});

  assign regbank_sel    = sel_q;
  assign regbank_rsel   = sel_q;
  assign regbank_valout = val_q;

  ctl_byte_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_byte_seq (
    .clk         (clk),
    .rst         (rst),
    .start       (seq_start),
    .base        (base_q),
    .count       (nbytes(size_q)),
    .we          (seq_we),
    .wdata       (regbank_rdata),
    .bus_ack     (bus_ack),
    .bus_data_in (bus_data_in),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .rbyte       (rbyte),
    .rvalid      (rvalid),
    .last        (seq_last),
    .idx         (idx)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operation latch, read accumulator and write-back value register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      sel_q  <= '0;
      size_q <= '0;
      base_q <= '0;
      acc    <= '0;
      val_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= ctl_op;
        sel_q  <= reg_sel;
        size_q <= size;
        base_q <= data_in[ADDR_W-1:0];
        if (ctl_op == CTL_LOAD_IMM) val_q <= data_in;
      end
      if (state == EXEC) begin
        acc <= '0;
      end else if (rvalid) begin
        acc <= acc_nxt;
        // Final byte: freeze the assembled word for the WB cycle and beyond.
        if (seq_last) val_q <= acc_nxt;
      end
    end
  end

  // Next-state decode and completion/strobe outputs.
  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    err        = 1'b0;
    regbank_we = 1'b0;
    seq_start  = 1'b0;
    seq_we     = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        state_nxt = IDLE;
        case (op_q)
          CTL_NOP: done = 1'b1;
          CTL_LOAD_IMM: begin
            regbank_we = 1'b1;
            done       = 1'b1;
          end
          CTL_READ_ADDR: begin
            if (too_big) begin
              done = 1'b1;
              err  = 1'b1;
            end else begin
              seq_start = 1'b1;
              state_nxt = BUS;
            end
          end
          CTL_WRITE_ADDR: begin
            if (too_big) begin
              done = 1'b1;
              err  = 1'b1;
            end else begin
              state_nxt = RSRC;
            end
          end
          default: begin
            done = 1'b1;
            err  = 1'b1;
          end
        endcase
      end
      RSRC: begin
        // regbank_rdata for sel_q is captured by the byte sequencer at this edge.
        seq_start = 1'b1;
        seq_we    = 1'b1;
        state_nxt = BUS;
      end
      BUS: begin
        if (seq_last) begin
          if (bus_we) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        regbank_we = 1'b1;
        done       = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/ctl_seq.md
Name: ctl_seq

Overview:
- Next-generation control unit. Accepts one control operation at a time over a valid/ready handshake and sequences it to the register bank and the byte-wide bus unit.
- Parametrised in data, address and register-select widths.
- Adds four things single-cycle control lacks: multi-byte little-endian loads and stores, a req/ack bus handshake, done/err completion pulses, and reset.
- Sits between instruction decode and the regbank/bus unit.

Parameters:
- DATA_W, 64, register data width; must be a multiple of 8 and at most 64.
- ADDR_W, 17, bus address width.
- SEL_W, 6, register-select width.
- CTL_NOP, 8'h00, no-op opcode.
- CTL_LOAD_IMM, 8'h01, load immediate into register.
- CTL_READ_ADDR, 8'h02, load 1/2/4/8 bytes from bus into register.
- CTL_WRITE_ADDR, 8'h03, store 1/2/4/8 low register bytes to bus.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  operation present.
- op_ready  out  1  block can accept an operation.
- ctl_op  in  8  opcode.
- reg_sel  in  SEL_W  target/source register.
- size  in  2  byte count = 1<<size.
- data_in  in  DATA_W  immediate (LOAD_IMM) or base address in data_in[ADDR_W-1:0].
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- regbank_we  out  1  register write strobe.
- regbank_sel  out  SEL_W  write select.
- regbank_valout  out  DATA_W  write data.
- regbank_rsel  out  SEL_W  read select.
- regbank_rdata  in  DATA_W  combinational read data for regbank_rsel.
- bus_req  out  1  bus transfer request.
- bus_we  out  1  1 = write, 0 = read.
- bus_ack  in  1  bus unit completes the current byte.
- addr_out  out  ADDR_W  byte address.
- data_out  out  8  write byte.
- bus_data_in  in  8  read byte, valid with bus_ack.

Behaviour:
- Reset: rst high at a posedge forces state IDLE and zeroes every registered output and internal register (accumulator, byte counter). op_ready = (state==IDLE) && !rst.
- Reset mid-operation: the in-flight transfer is abandoned. bus_req is low the cycle after the reset edge, and no regbank_we, done or err is issued for the abandoned operation.
- Accept: an operation is accepted on the posedge where op_valid && op_ready. ctl_op, reg_sel, size and data_in are latched; op_ready is low until return to IDLE.
- FSM states: IDLE, EXEC, RSRC, BUS, WB.
- IDLE -> EXEC on accept. EXEC decodes the latched op:
  - NOP: done=1 in EXEC, then IDLE. Latency 1.
  - LOAD_IMM: regbank_we=1, regbank_sel=reg_sel, regbank_valout=data_in, done=1, all for one cycle in EXEC, then IDLE. Latency 1.
  - READ_ADDR: accumulator is cleared, byte index i=0, go to BUS with bus_we=0.
  - WRITE_ADDR: go to RSRC.
  - Unknown opcode: done=1 and err=1 in EXEC, with no regbank or bus activity. Then IDLE.
  - Error case: for READ_ADDR or WRITE_ADDR, if (1<<size)*8 > DATA_W then done=1 and err=1 in EXEC, with no side effects. Then IDLE.
- RSRC (one cycle): regbank_rsel=reg_sel. regbank_rdata is captured into a shift register at the end of the cycle; then i=0, go to BUS with bus_we=1.
- BUS transfer, byte i:
  - bus_req=1, addr_out = base + i, truncated to ADDR_W (wraps from 2^ADDR_W-1 to 0).
  - For writes, data_out = byte i of the captured value.
  - addr_out, bus_we and data_out are held stable while bus_req && !bus_ack.
  - On the posedge with bus_ack: a read stores bus_data_in into accumulator byte i; then i increments.
  - If bytes remain, bus_req stays high and the next address/data appear the following cycle, giving back-to-back transfers.
  - After the last ack, bus_req drops. A read goes to WB; a write pulses done and returns to IDLE.
- WB (one cycle): regbank_we=1, regbank_sel=reg_sel, regbank_valout = accumulator zero-extended to DATA_W, done=1. Then IDLE.
- bus_ack while bus_req is low is ignored. op_valid outside IDLE is ignored.
- Outputs regbank_we, done, err and bus_req are strobes: low in every state where not explicitly asserted. Data outputs hold their last value.
- Latency for READ_ADDR with zero-wait acks: accept, +1 EXEC, +n BUS, +1 WB, so done arrives n+2 cycles after accept. WRITE_ADDR adds RSRC, so done arrives n+2 cycles after accept on the last BUS cycle.

Decomposition:
- Package ctl_pkg holds:
  - opcode constants;
  - state enum ctl_state_t (IDLE, EXEC, RSRC, BUS, WB);
  - size code constants SZ_1, SZ_2, SZ_4, SZ_8;
  - function nbytes(size).
- One sub-module, ctl_byte_seq: owns the byte counter, the address increment/wrap, and bus_req/ack sequencing. It takes start/base/count/we/wdata and returns rbyte/rvalid/last.

Test Plan:
- Reset, then LOAD_IMM: reg_sel=5, data_in=64'hDEAD_BEEF_0123_4567. Required: next cycle regbank_we=1, sel=5, valout=64'hDEAD_BEEF_0123_4567, done=1; op_ready back high the following cycle.
- READ_ADDR: size=2, base=17'h00010, ack every cycle, bus bytes 11,22,33,44. Required: addr_out 0x10..0x13, then WB with valout=64'h0000_0000_4433_2211, done 6 cycles after accept.
- WRITE_ADDR: size=1, base=17'h1FFFF, regbank_rdata=64'hABCD, ack delayed 3 cycles per byte. Required: addr_out=0x1FFFF with data_out=CD, then 0x00000 with data_out=AB; each held stable until ack; single done pulse.
- Unknown opcode 8'h7F, then READ_ADDR with DATA_W=32 and size=3. Required: each gives done=1 and err=1 one cycle after accept, with no regbank_we and no bus_req.
- rst asserted during byte 2 of an 8-byte read. Required: bus_req=0 next cycle, no regbank_we, no done; a following LOAD_IMM completes normally.
- Stray bus_ack=1 in IDLE, and op_valid held high while busy. Required: no state change, and the second operation is accepted only after done.
